data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Multi-cycle responder for the pipeline's data-memory request interface: it accepts a chip-select/write-enable request from the MEM stage, services it from an internal word array after a programmable latency, and signals completion with a one-cycle ready pulse. It sits between the EX/MEM latch outputs and the MEM/WB latch. Its `busy_o` output drives the pipeline stall path while an access is outstanding.

## Interface
- `SIZE`, 32: number of 32-bit words in the array.
- `LATENCY`, 2: count of BUSY cycles per access; legal range 1–15.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous, active-low.
- `cs`  in  1: request valid / chip select.
- `we`  in  1: 1 = write, 0 = read; sampled with `cs`.
- `addr_i`  in  32: byte address; word index = `addr_i[31:2]`.
- `data_i`  in  32: write data.
- `data_o`  out  32: read data; valid while `ready_o` = 1 and held afterwards.
- `ready_o`  out  1: one-cycle completion pulse.
- `busy_o`  out  1: an access is outstanding; the pipeline must stall.
- `err_o`  out  1: error flag, qualified by `ready_o`.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE:** if `cs` = 1 at the edge, capture `we`, `addr_i`, `data_i`, set `cnt = LATENCY-1`, go to BUSY. Otherwise stay in IDLE.
- **BUSY:** `busy_o` = 1. While `cnt != 0`, decrement `cnt`. At `cnt == 0`, go to DONE, and on that same edge:
  - **Read:** `data_o` ← `mem[idx]`.
  - **Write:** `mem[idx]` ← captured data; `data_o` is unchanged.
  - **Error:** the write is suppressed, `data_o` ← 0, and `err_o` ← 1.
- **DONE:** `ready_o` = 1 and `busy_o` = 0 for exactly one cycle.
  - If `cs` = 1 at the edge, the new request is captured and the FSM goes to BUSY (back-to-back).
  - Otherwise the FSM goes to IDLE.
- Inputs are ignored in BUSY; no queuing.
- **Range error:** captured word index ≥ `SIZE`.
- The array is not cleared by reset. Only control state and outputs are reset.
- **Reset mid-access:** the access is abandoned, and a pending write is never committed.

## Timing
- Reset values: `data_o` = 0, `ready_o` = 0, `busy_o` = 0, `err_o` = 0; state = IDLE; `cnt` = 0.
- Request accepted at edge E: `busy_o` is high for cycles E+1 … E+LATENCY.
- `ready_o` is high in the cycle after edge E+LATENCY.
- **Throughput:** one access per LATENCY+1 cycles when requests are back-to-back.
- **LATENCY = 1:** one BUSY cycle, then DONE.
- **Write visibility:** a read accepted in DONE of a write to the same index returns the new data.
- `err_o` and `ready_o` rise and fall together. `err_o` is 0 whenever `ready_o` is 0.
- **`rst` falling mid-cycle:** outputs clear immediately, without waiting for a clock edge.

## Configuration
- `DMEM_ALIGN_CHECK_EN`
  - **Defined:** a captured `addr_i[1:0]` ≠ 0 is an error, handled exactly like a range error (write suppressed, `data_o` = 0, `err_o` = 1 with `ready_o`).
  - **Undefined:** `addr_i[1:0]` is ignored, and misaligned addresses access word `addr_i[31:2]` normally.

## Test plan
- **Reset then write/read** (LATENCY=2): write `0xDEADBEEF` @ `0x10`, then read @ `0x10` → `busy_o` high for 2 cycles, `ready_o` pulses 2 cycles after each accept, `data_o` = `0xDEADBEEF`, `err_o` = 0.
- **Back-to-back:**
  - Stimulus: hold `cs` = 1 and issue writes @ `0x0` = 1 then `0x4` = 2, followed by reads of both.
  - Response: a `ready_o` pulse every 3 cycles; reads return 1 and 2.
- **Out of range** (SIZE=32): write `0x5` @ `0x80`, then read @ `0x80`.
  - Both complete with `err_o` = 1 and `data_o` = 0.
  - A read @ `0x0` is unaffected.
- **Misaligned** @ `0x11`:
  - With `DMEM_ALIGN_CHECK_EN` defined: `err_o` = 1, no write.
  - Without it: the access hits word 4 with `err_o` = 0.
- **Ignored input:** toggle `cs` with a different address during BUSY → the original access completes unchanged, and no extra `ready_o` appears.
- **Reset mid-access:**
  - Stimulus: assert `rst` = 0 during BUSY of a write @ `0x8` = `0x77`, release it, then read @ `0x8`.
  - Response: outputs are 0 immediately on reset; the read returns the old contents, not `0x77`.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response bundle between the MEM stage and
// the data-memory responder.
//   cs, we, addr_i, data_i      : request (driven by the master)
//   data_o, ready_o, busy_o,    : response (driven by the slave)
//   err_o
interface data_mem_responder_if;
  logic        cs;
  logic        we;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        ready_o;
  logic        busy_o;
  logic        err_o;

  modport master (
    output cs, we, addr_i, data_i,
    input  data_o, ready_o, busy_o, err_o
  );

  modport slave (
    input  cs, we, addr_i, data_i,
    output data_o, ready_o, busy_o, err_o
  );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data-memory responder for the MEM stage.
// A request (cs/we/addr_i/data_i) is captured in IDLE or DONE, held for
// LATENCY BUSY cycles, then serviced from an internal word array; completion
// is a one-cycle ready_o pulse with err_o qualifying it.
//
// Parameters:
//   SIZE    : number of 32-bit words in the array
//   LATENCY : BUSY cycles per access (1..15)
// Ports:
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset (control state and outputs only;
//             the array contents survive reset)
//   bus     : data_mem_responder_if.slave request/response bundle
// Build option:
//   DMEM_ALIGN_CHECK_EN : when defined, addr_i[1:0] != 0 is treated as an
//                         error exactly like an out-of-range word index.
module data_mem_responder #(
  parameter int unsigned SIZE    = 32,
  parameter int unsigned LATENCY = 2
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);

  localparam int unsigned AW = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic        accept;
  logic        finish;

  // Captured request
  logic          req_we;
  logic [AW-1:0] req_idx;
  logic [31:0]   req_data;
  logic          req_err;

  logic [31:0] mem [SIZE];
  logic [31:0] data_q;
  logic        err_q;

  logic [31:0] word_idx;
  logic        addr_err;

  // Error is decided at capture time from the full word index, so only the
  // low AW index bits need to be kept.
  assign word_idx = {2'b00, bus.addr_i[31:2]};

`ifdef DMEM_ALIGN_CHECK_EN
  assign addr_err = (word_idx >= SIZE) || (bus.addr_i[1:0] != 2'b00);
`else
  logic align_unused;
  assign align_unused = ^bus.addr_i[1:0];
  assign addr_err     = (word_idx >= SIZE);
`endif

  // Next-state / control
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cs) begin
          accept    = 1'b1;
          state_nxt = BUSY;
          cnt_nxt   = 4'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      DONE: begin
        if (bus.cs) begin
          accept    = 1'b1;
          state_nxt = BUSY;
          cnt_nxt   = 4'(LATENCY - 1);
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, captured request and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      req_we   <= 1'b0;
      req_idx  <= '0;
      req_data <= '0;
      req_err  <= 1'b0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        req_we   <= bus.we;
        req_idx  <= bus.addr_i[AW+1:2];
        req_data <= bus.data_i;
        req_err  <= addr_err;
      end
      if (finish) begin
        if (req_err) begin
          data_q <= '0;
        end else if (!req_we) begin
          data_q <= mem[req_idx];
        end
      end
      // err_o is only ever high during DONE, so it tracks ready_o exactly.
      err_q <= finish & req_err;
    end
  end

  // Array: no reset. A reset during BUSY forces IDLE asynchronously, so
  // finish can never fire for an abandoned access.
  always_ff @(posedge clk) begin
    if (finish && req_we && !req_err) begin
      mem[req_idx] <= req_data;
    end
  end

  assign bus.busy_o  = (state == BUSY);
  assign bus.ready_o = (state == DONE);
  assign bus.data_o  = data_q;
  assign bus.err_o   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  data_mem_responder_if bus ();

  data_mem_responder #(
    .SIZE   (32),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic        exp_err;
    bit          chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request, wait (bounded) for ready_o, report what was seen.
  task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input bit noise, output logic [31:0] rd, output logic e,
                        output int nbusy, output int rdy_at, output bit err_leak);
    @(negedge clk);
    bus.cs = 1'b1; bus.we = w; bus.addr_i = a; bus.data_i = d;
    @(posedge clk);
    nbusy = 0; rdy_at = 0; err_leak = 0; rd = '0; e = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.busy_o) nbusy++;
      if (bus.err_o && !bus.ready_o) err_leak = 1;
      if (bus.ready_o) begin
        rd = bus.data_o; e = bus.err_o; rdy_at = k;
        bus.cs = 1'b0;
        break;
      end
      if (noise && k == 1) begin
        bus.cs = 1'b1; bus.we = 1'b1; bus.addr_i = 32'h0; bus.data_i = 32'hBAD0BAD0;
      end else begin
        bus.cs = 1'b0;
      end
    end
    bus.cs = 1'b0;
  endtask

  logic [31:0] rd;
  logic        e;
  int          nb, ra, nrdy, idx, cyc;
  bit          leak;
  logic [31:0] bb_a[4];
  logic [31:0] bb_d[4];
  logic        bb_w[4];
  int          rdy_cyc[4];
  logic [31:0] got[4];

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0;
    bus.cs = 1'b0; bus.we = 1'b0; bus.addr_i = '0; bus.data_i = '0;

    vecs[0]  = '{1'b1, 32'h0000_0000, 32'h1111_1111, 1'b0, 1'b1, 32'h0};
    vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 1'b1, 32'h1111_1111};
    vecs[4]  = '{1'b1, 32'h0000_0080, 32'h0000_0005, 1'b1, 1'b1, 32'h0};
    vecs[5]  = '{1'b0, 32'h0000_0080, 32'h0,         1'b1, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 32'h0000_007C, 32'h7C7C_7C7C, 1'b0, 1'b1, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 1'b1, 32'h1111_1111};
    vecs[8]  = '{1'b0, 32'h0000_007C, 32'h0,         1'b0, 1'b1, 32'h7C7C_7C7C};
`ifdef DMEM_ALIGN_CHECK_EN
    vecs[9]  = '{1'b1, 32'h0000_0011, 32'hA5A5_A5A5, 1'b1, 1'b1, 32'h0};
    vecs[10] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[12] = '{1'b0, 32'h0000_0013, 32'h0,         1'b1, 1'b1, 32'h0};
`else
    vecs[9]  = '{1'b1, 32'h0000_0011, 32'hA5A5_A5A5, 1'b0, 1'b1, 32'h7C7C_7C7C};
    vecs[10] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hA5A5_A5A5};
    vecs[12] = '{1'b0, 32'h0000_0013, 32'h0,         1'b0, 1'b1, 32'hA5A5_A5A5};
`endif
    vecs[11] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         1'b1, 1'b1, 32'h0};

    // Reset state
    #3;
    check("rst_data", bus.data_o, 32'h0);
    check("rst_ready", {31'b0, bus.ready_o}, 32'h0);
    check("rst_busy", {31'b0, bus.busy_o}, 32'h0);
    check("rst_err", {31'b0, bus.err_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven accesses
    for (int i = 0; i < 13; i++) begin
      access(vecs[i].w, vecs[i].a, vecs[i].d, 1'b0, rd, e, nb, ra, leak);
      check($sformatf("v%0d_ready_at", i), 32'(ra), 32'(LAT + 1));
      check($sformatf("v%0d_busy_cycles", i), 32'(nb), 32'(LAT));
      check($sformatf("v%0d_err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
      check($sformatf("v%0d_err_unqualified", i), {31'b0, leak}, 32'h0);
      if (vecs[i].chk_data) check($sformatf("v%0d_data", i), rd, vecs[i].exp_data);
      @(negedge clk);
      check($sformatf("v%0d_ready_single", i), {31'b0, bus.ready_o}, 32'h0);
    end

    // Inputs toggled during BUSY are ignored
    access(1'b0, 32'h0000_007C, 32'h0, 1'b1, rd, e, nb, ra, leak);
    check("ign_ready_at", 32'(ra), 32'(LAT + 1));
    check("ign_data", rd, 32'h7C7C_7C7C);
    check("ign_err", {31'b0, e}, 32'h0);
    nrdy = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.ready_o) nrdy++;
    end
    check("ign_extra_ready", 32'(nrdy), 32'h0);
    access(1'b0, 32'h0000_0000, 32'h0, 1'b0, rd, e, nb, ra, leak);
    check("ign_word0_intact", rd, 32'h1111_1111);

    // Back-to-back with cs held high
    bb_w[0] = 1'b1; bb_a[0] = 32'h0; bb_d[0] = 32'h1;
    bb_w[1] = 1'b1; bb_a[1] = 32'h4; bb_d[1] = 32'h2;
    bb_w[2] = 1'b0; bb_a[2] = 32'h0; bb_d[2] = 32'h0;
    bb_w[3] = 1'b0; bb_a[3] = 32'h4; bb_d[3] = 32'h0;
    for (int k = 0; k < 4; k++) begin rdy_cyc[k] = 0; got[k] = '0; end
    @(negedge clk);
    bus.cs = 1'b1; bus.we = bb_w[0]; bus.addr_i = bb_a[0]; bus.data_i = bb_d[0];
    idx = 0; cyc = 0;
    while (idx < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.ready_o) begin
        rdy_cyc[idx] = cyc;
        got[idx] = bus.data_o;
        idx++;
        if (idx < 4) begin
          bus.we = bb_w[idx]; bus.addr_i = bb_a[idx]; bus.data_i = bb_d[idx];
        end else begin
          bus.cs = 1'b0;
        end
      end
    end
    bus.cs = 1'b0;
    check("bb_all_done", 32'(idx), 32'd4);
    check("bb_first_ready", 32'(rdy_cyc[0]), 32'(LAT + 1));
    for (int k = 1; k < 4; k++)
      check($sformatf("bb_gap%0d", k), 32'(rdy_cyc[k] - rdy_cyc[k-1]), 32'(LAT + 1));
    check("bb_read0", got[2], 32'h1);
    check("bb_read4", got[3], 32'h2);

    // Reset in the middle of a write
    access(1'b1, 32'h0000_0008, 32'h1234_5678, 1'b0, rd, e, nb, ra, leak);
    access(1'b0, 32'h0000_0008, 32'h0, 1'b0, rd, e, nb, ra, leak);
    check("mr_pre_read", rd, 32'h1234_5678);
    @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b1; bus.addr_i = 32'h8; bus.data_i = 32'h77;
    @(posedge clk);
    @(negedge clk);
    bus.cs = 1'b0;
    check("mr_busy_before", {31'b0, bus.busy_o}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_busy", {31'b0, bus.busy_o}, 32'h0);
    check("mr_ready", {31'b0, bus.ready_o}, 32'h0);
    check("mr_err", {31'b0, bus.err_o}, 32'h0);
    check("mr_data", bus.data_o, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 32'h0000_0008, 32'h0, 1'b0, rd, e, nb, ra, leak);
    check("mr_ready_at", 32'(ra), 32'(LAT + 1));
    check("mr_old_contents", rd, 32'h1234_5678);
    check("mr_err_after", {31'b0, e}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
